pipe_stage_fifo: RTL and testbench

Parametrised elastic pipeline-stage buffer for the RV32I pipeline: replaces a fixed single-entry stage register between two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with a DEPTH-entry valid/ready queue carrying an opaque packed stage-register payload of WIDTH bits. It adds back-pressure, a synchronous flush for branch/jump redirects, occupancy reporting and a 64-bit retirement-order tag stamped on each entry as it leaves the buffer.

---
 rtl/pipe_stage_fifo.sv | 90 +++++++++
 tb/tb_pipe_stage_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Elastic valid/ready buffer between two pipeline stages: DEPTH-entry queue of
// opaque WIDTH-bit payloads with synchronous flush and a 64-bit pop-order tag.
module pipe_stage_fifo #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [63:0]                out_order,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // A one-entry buffer still needs a 1-bit pointer; the spare slot is never addressed.
   localparam int MD = (DEPTH > 1) ? DEPTH : 2;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [MD];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [63:0]      order_q, order_d;
   logic             push;
   logic             pop;

   // Readiness depends only on held state, so a full buffer never passes through.
   assign in_ready  = !rst && !flush && (count_q != FULL);
   assign out_valid = !flush && (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = mem_q[rd_ptr_q];
   assign out_order = order_q;
   assign count     = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      order_d  = order_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
            order_d  = order_q + 64'd1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Flushed entries were never popped, so the order tag survives a flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         order_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         order_q  <= order_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo at DEPTH 1..4 with a queue scoreboard
// and a bench-side occupancy/order model.
module tb_pipe_stage_fifo;

   logic        clk;
   logic        rst;
   logic        in_valid  [4];
   logic        out_ready [4];
   logic        flush     [4];
   logic        in_ready  [4];
   logic        out_valid [4];
   logic [7:0]  in_data   [4];
   logic [7:0]  out_data  [4];
   logic [63:0] out_order [4];
   logic [2:0]  cnt       [4];

   // Instance gi has DEPTH = gi + 1.
   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int D  = gi + 1;
      localparam int CW = $clog2(D + 1);
      logic [CW-1:0] c;
      pipe_stage_fifo #(.WIDTH(8), .DEPTH(D)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[gi]),
         .in_ready  (in_ready[gi]),
         .in_data   (in_data[gi]),
         .out_valid (out_valid[gi]),
         .out_ready (out_ready[gi]),
         .out_data  (out_data[gi]),
         .out_order (out_order[gi]),
         .flush     (flush[gi]),
         .count     (c)
      );
      assign cnt[gi] = 3'(c);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vecs = 0;
   int          errs = 0;
   int          dut_pops = 0;
   logic [7:0]  sb_q[$];
   logic [63:0] exp_order = 64'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle on instance k, entered and left just after a falling edge.
   task automatic cyc(input int k, input bit v, input bit r, input bit f, input logic [7:0] d);
      int dep;
      bit exp_ir;
      bit exp_ov;
      dep          = k + 1;
      in_valid[k]  = v;
      out_ready[k] = r;
      flush[k]     = f;
      in_data[k]   = d;
      #1;
      exp_ir = !f && (sb_q.size() != dep);
      exp_ov = !f && (sb_q.size() != 0);
      chk("in_ready", 64'(in_ready[k]), 64'(exp_ir));
      chk("out_valid", 64'(out_valid[k]), 64'(exp_ov));
      chk("count", 64'(cnt[k]), 64'(sb_q.size()));
      if (out_valid[k] && out_ready[k]) dut_pops++;
      if (exp_ov && r) begin
         chk("out_data", 64'(out_data[k]), 64'(sb_q[0]));
         chk("out_order", out_order[k], exp_order);
         void'(sb_q.pop_front());
         exp_order++;
      end
      if (v && exp_ir) sb_q.push_back(d);
      if (f) sb_q.delete();
      $display("cyc k=%0d v=%0b r=%0b f=%0b d=%02h ir=%0b ov=%0b od=%02h ord=%0d cnt=%0d",
               k, v, r, f, d, in_ready[k], out_valid[k], out_data[k], out_order[k], cnt[k]);
      @(posedge clk);
      @(negedge clk);
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      flush[k]     = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      sb_q.delete();
      exp_order = 64'd0;
      dut_pops  = 0;
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         flush[k]     = 1'b0;
         in_data[k]   = 8'h00;
      end
      #3;
      chk("rst_out_valid", 64'(out_valid[1]), 64'd0);
      chk("rst_in_ready", 64'(in_ready[1]), 64'd0);
      chk("rst_count", 64'(cnt[1]), 64'd0);
      chk("rst_out_order", out_order[1], 64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      // Fill and drain, DEPTH=2.
      cyc(1, 1, 0, 0, 8'h11);
      cyc(1, 1, 0, 0, 8'h22);
      cyc(1, 1, 0, 0, 8'h33);
      cyc(1, 0, 1, 0, 8'h00);
      cyc(1, 0, 1, 0, 8'h00);
      cyc(1, 0, 0, 0, 8'h00);

      // Async reset between edges with two entries held.
      cyc(1, 1, 0, 0, 8'h44);
      cyc(1, 1, 0, 0, 8'h55);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid[1]), 64'd0);
      chk("arst_in_ready", 64'(in_ready[1]), 64'd0);
      chk("arst_count", 64'(cnt[1]), 64'd0);
      chk("arst_out_order", out_order[1], 64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      sb_q.delete();
      exp_order = 64'd0;
      cyc(1, 1, 0, 0, 8'h66);
      cyc(1, 0, 1, 0, 8'h00);

      // Streaming, DEPTH=2.
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 8'(i));
      cyc(1, 0, 1, 0, 8'h00);
      cyc(1, 0, 0, 0, 8'h00);

      // DEPTH=3 pointer wrap with stalls.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(2, 1, 0, 0, 8'(8'h30 + i));
      for (int i = 0; i < 20; i++) cyc(2, (i % 4) != 3, (i % 3) != 0, 0, 8'(8'h40 + i));
      for (int i = 0; i < 4; i++) cyc(2, 0, 1, 0, 8'h00);

      // Flush, DEPTH=4, holding 3 entries at order 7.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         cyc(3, 1, 0, 0, 8'(8'h70 + i));
         cyc(3, 0, 1, 0, 8'h00);
      end
      for (int i = 0; i < 3; i++) cyc(3, 1, 0, 0, 8'(8'hA0 + i));
      chk("pre_flush_order", out_order[3], 64'd7);
      cyc(3, 1, 1, 1, 8'hEE);
      cyc(3, 0, 0, 0, 8'h00);
      cyc(3, 1, 0, 0, 8'h5A);
      cyc(3, 0, 1, 0, 8'h00);

      // DEPTH=1 throughput.
      do_reset();
      for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 8'(8'hC0 + i));
      chk("d1_pops", 64'(dut_pops), 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
